// File: rtl/pipelined_adder.sv
// Pipelined N-bit add/subtract built from CHUNK-bit ripple segments, one register stage per segment.
// Optional macro PIPELINED_ADDER_SATURATE_EN clamps sum to the signed limit on overflow.
module pipelined_adder #(
  parameter int N     = 8,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  if (CHUNK < 1 || (N % CHUNK) != 0) begin : g_bad_cfg
    $error("pipelined_adder: N must be a positive multiple of CHUNK");
  end

  localparam int S = N / CHUNK;

  // Handshake: a transfer happens on a side when its valid and ready are both high
  // at the rising edge; the whole pipeline moves together only when advance is high.
  logic advance;

  // Stage registers: operand skew (b already inverted for subtract), partial result, carry, valid.
  logic [N-1:0] a_q   [S];
  logic [N-1:0] b_q   [S];
  logic [N-1:0] res_q [S];
  logic [S-1:0] c_q;
  logic [S-1:0] v_q;
  logic         ovf_q;

  // What each stage sees at its input: stage 0 from the ports, stage k from stage k-1.
  logic [N-1:0] a_s   [S];
  logic [N-1:0] b_s   [S];
  logic [N-1:0] r_s   [S];
  logic [S-1:0] c_s;
  logic [S-1:0] v_s;

  logic [CHUNK:0] part  [S];
  logic [N-1:0]   res_d [S];
  logic           ovf_d;
  logic           msb_carry_in;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    a_s[0] = a;
    b_s[0] = sub ? ~b : b;
    r_s[0] = '0;
    c_s[0] = sub | cin;
    v_s[0] = in_valid;
    for (int k = 1; k < S; k++) begin
      a_s[k] = a_q[k-1];
      b_s[k] = b_q[k-1];
      r_s[k] = res_q[k-1];
      c_s[k] = c_q[k-1];
      v_s[k] = v_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < S; k++) begin
      part[k] = {1'b0, a_s[k][k*CHUNK +: CHUNK]}
              + {1'b0, b_s[k][k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, c_s[k]};
      res_d[k] = r_s[k];
      res_d[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
    end
    // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
    msb_carry_in = a_s[S-1][N-1] ^ b_s[S-1][N-1] ^ part[S-1][CHUNK-1];
    ovf_d        = msb_carry_in ^ part[S-1][CHUNK];
`ifdef PIPELINED_ADDER_SATURATE_EN
    if (ovf_d) begin
      res_d[S-1] = a_s[S-1][N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
`endif
  end

  // Data registers load only alongside a valid token, so sum stays at its reset value
  // until the first real result appears.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < S; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
      end
      c_q   <= '0;
      v_q   <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < S; k++) begin
        v_q[k] <= v_s[k];
        if (v_s[k]) begin
          a_q[k]   <= a_s[k];
          b_q[k]   <= b_s[k];
          res_q[k] <= res_d[k];
          c_q[k]   <= part[k][CHUNK];
        end
      end
      if (v_s[S-1]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = v_q[S-1];
  assign sum       = res_q[S-1];
  assign cout      = c_q[S-1];
  assign ovf       = ovf_q;

endmodule
